// File: rtl/key_event_fifo_pkg.sv
// Shared keypad definitions: key-code width, scan window geometry, debounce FSM states.
package key_event_fifo_pkg;

  localparam int unsigned KEY_W   = 4;  // key code width (row*4+col)
  localparam int unsigned WIN_LEN = 4;  // scan window length in cycles
  localparam int unsigned WIN_W   = 2;  // width of the window counter
  localparam int unsigned CNT_W   = 4;  // debounce/release counter width (limits up to 15)

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } key_state_e;

  // Summary of one scan window as seen by the debounce FSM
  typedef struct packed {
    logic             hit;
    logic [KEY_W-1:0] code;
  } win_sample_t;

endpackage

// File: rtl/key_event_fifo_fifo.sv
// Parameterised first-word-fall-through FIFO holding accepted key codes.
module key_fifo
  import key_event_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = KEY_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [W-1:0]               data_i,
  input  logic                       pop_i,
  output logic [W-1:0]               head_c,
  output logic                       full_c,
  output logic                       drop_c,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          empty_c;
  logic          do_pop_c;
  logic          do_push_c;

  // Full/empty decode; a pop frees the slot so a simultaneous push is accepted even when full
  always_comb begin
    empty_c   = (count_q == CW'(0));
    full_c    = (count_q == CW'(DEPTH));
    do_pop_c  = pop_i & ~empty_c;
    do_push_c = push_i & (~full_c | do_pop_c);
    drop_c    = push_i & full_c & ~do_pop_c;
    head_c    = empty_c ? W'(0) : mem_q[rd_ptr_q];
  end

  // Storage, pointers (wrap naturally, DEPTH is a power of two) and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push_c) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop_c) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push_c && !do_pop_c)      count_q <= count_q + CW'(1);
      else if (do_pop_c && !do_push_c) count_q <= count_q - CW'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/key_event_fifo.sv
// Debounces keypad scanner hits per scan window and queues one event per key press.
module key_event_fifo
  import key_event_fifo_pkg::*;
#(
  parameter int unsigned STABLE_SCANS  = 4,
  parameter int unsigned RELEASE_SCANS = 4,
  parameter int unsigned DEPTH         = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] posicion,
  input  logic             opr,
  input  logic             rd_en,
  input  logic             clr_ovf,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  output logic             full,
  output logic             overflow,
  output logic             press_pulse,
  output logic             release_pulse
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIN_W-1:0] win_cnt_q;
  logic             hit_acc_q;
  logic [KEY_W-1:0] code_acc_q;
  logic             win_end_c;
  win_sample_t      sample_c;

  key_state_e       state_q, state_d;
  logic [KEY_W-1:0] cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc_c;
  logic             push_c, rel_c;

  logic             press_pulse_q, release_pulse_q, overflow_q;
  logic             fifo_full_c, fifo_drop_c;
  logic [CW-1:0]    fifo_count;

  // Window summary, including a hit seen on the closing cycle itself
  always_comb begin
    win_end_c     = (win_cnt_q == WIN_W'(WIN_LEN - 1));
    sample_c.hit  = hit_acc_q | ~opr;
    sample_c.code = ~opr ? posicion : code_acc_q;
  end

  // Free-running window counter and per-window hit accumulator (last hit wins)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt_q  <= '0;
      hit_acc_q  <= 1'b0;
      code_acc_q <= '0;
    end else begin
      win_cnt_q <= win_cnt_q + WIN_W'(1);
      if (win_end_c) begin
        hit_acc_q <= 1'b0;
      end else if (!opr) begin
        hit_acc_q  <= 1'b1;
        code_acc_q <= posicion;
      end
    end
  end

  // Debounce FSM next state, advanced only at window end
  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    push_c    = 1'b0;
    rel_c     = 1'b0;
    cnt_inc_c = cnt_q + CNT_W'(1);
    if (win_end_c) begin
      unique case (state_q)
        ST_IDLE: begin
          if (sample_c.hit) begin
            state_d = ST_DEBOUNCE;
            cand_d  = sample_c.code;
            cnt_d   = CNT_W'(1);
          end
        end
        ST_DEBOUNCE: begin
          if (sample_c.hit && sample_c.code == cand_q) begin
            if (cnt_inc_c == CNT_W'(STABLE_SCANS)) begin
              state_d = ST_HELD;
              cnt_d   = '0;
              push_c  = 1'b1;
            end else begin
              cnt_d = cnt_inc_c;
            end
          end else if (sample_c.hit) begin
            cand_d = sample_c.code;
            cnt_d  = CNT_W'(1);
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
        ST_HELD: begin
          if (!sample_c.hit) begin
            state_d = ST_RELEASE;
            cnt_d   = CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          if (sample_c.hit) begin
            state_d = ST_HELD;
            cnt_d   = '0;
          end else if (cnt_inc_c == CNT_W'(RELEASE_SCANS)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            rel_c   = 1'b1;
          end else begin
            cnt_d = cnt_inc_c;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // FSM state, strobes and sticky overflow (a new drop wins over clear)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      cand_q          <= '0;
      cnt_q           <= '0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      overflow_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      cand_q          <= cand_d;
      cnt_q           <= cnt_d;
      press_pulse_q   <= push_c;
      release_pulse_q <= rel_c;
      if (fifo_drop_c)  overflow_q <= 1'b1;
      else if (clr_ovf) overflow_q <= 1'b0;
    end
  end

  key_fifo #(
    .DEPTH (DEPTH),
    .W     (KEY_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_c),
    .data_i  (cand_q),
    .pop_i   (rd_en),
    .head_c  (key_code),
    .full_c  (fifo_full_c),
    .drop_c  (fifo_drop_c),
    .count_o (fifo_count)
  );

  assign key_valid     = (fifo_count != CW'(0));
  assign full          = fifo_full_c;
  assign overflow      = overflow_q;
  assign press_pulse   = press_pulse_q;
  assign release_pulse = release_pulse_q;

endmodule

// File: tb/tb_key_event_fifo.sv
// Directed bench for key_event_fifo: debounce, release, FIFO limits, overflow, reset.
module tb_key_event_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] posicion;
  logic       opr;
  logic       rd_en;
  logic       clr_ovf;
  logic [3:0] key_code;
  logic       key_valid, full, overflow, press_pulse, release_pulse;

  int checks = 0;
  int errors = 0;
  int phase  = 0;  // bench copy of the window phase, restarted at each reset release

  key_event_fifo dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .posicion      (posicion),
    .opr           (opr),
    .rd_en         (rd_en),
    .clr_ovf       (clr_ovf),
    .key_code      (key_code),
    .key_valid     (key_valid),
    .full          (full),
    .overflow      (overflow),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    phase = (phase + 1) % 4;
  endtask

  // One scan window: a single hit on cycle 1 when hit=1, optional pop on the closing cycle
  task automatic win(input logic hit, input logic [3:0] code, input logic rd,
                     input logic exp_p, input logic exp_r, input string tag);
    while (phase != 0) tick();
    for (int i = 0; i < 4; i++) begin
      opr      = !(hit && i == 1);
      posicion = code;
      rd_en    = rd && (i == 3);
      tick();
    end
    opr   = 1'b1;
    rd_en = 1'b0;
    chk({tag, "_press"},   16'(press_pulse),   16'(exp_p));
    chk({tag, "_release"}, 16'(release_pulse), 16'(exp_r));
  endtask

  // Full press/release: 4 hit windows then 4 quiet windows
  task automatic press_seq(input logic [3:0] code, input logic rd_last, input string tag);
    for (int w = 0; w < 4; w++) win(1'b1, code, rd_last && (w == 3), w == 3, 1'b0, tag);
    for (int w = 0; w < 4; w++) win(1'b0, 4'h0, 1'b0, 1'b0, w == 3, tag);
  endtask

  task automatic pop();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  function automatic logic [15:0] outs();
    return {7'd0, key_code, key_valid, full, overflow, press_pulse, release_pulse};
  endfunction

  initial begin
    rst_n = 1'b0; posicion = 4'h5; opr = 1'b1; rd_en = 1'b0; clr_ovf = 1'b0;

    // 1. Reset with opr toggling
    for (int i = 0; i < 6; i++) begin
      opr = ~opr;
      @(posedge clk); #1;
    end
    chk("reset_outs", outs(), 16'h0);
    opr = 1'b1; rst_n = 1'b1; phase = 0;
    for (int w = 0; w < 3; w++) win(1'b0, 4'h5, 1'b0, 1'b0, 1'b0, "idle");
    chk("idle_valid", 16'(key_valid), 16'h0);

    // 2. Clean press of 0x5 for 6 windows, then 5 quiet windows
    for (int w = 0; w < 6; w++) begin
      win(1'b1, 4'h5, 1'b0, w == 3, 1'b0, "clean");
      if (w == 3) chk("clean_head", {11'd0, key_valid, key_code}, 16'h15);
    end
    for (int w = 0; w < 5; w++) win(1'b0, 4'h0, 1'b0, 1'b0, w == 3, "clean_rel");
    chk("clean_head2", 16'(key_code), 16'h5);
    pop();
    chk("clean_popped", {11'd0, key_valid, key_code}, 16'h00);

    // 3. Bounce: 2 hit windows, gap, 4 hit windows
    for (int w = 0; w < 2; w++) win(1'b1, 4'h5, 1'b0, 1'b0, 1'b0, "bounce_a");
    win(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, "bounce_gap");
    for (int w = 0; w < 4; w++) win(1'b1, 4'h5, 1'b0, w == 3, 1'b0, "bounce_b");
    for (int w = 0; w < 4; w++) win(1'b0, 4'h0, 1'b0, 1'b0, w == 3, "bounce_rel");
    chk("bounce_head", {11'd0, key_valid, key_code}, 16'h15);
    pop();

    // 4. Code change 0x3 -> 0x7, then 0xA while held is ignored
    for (int w = 0; w < 2; w++) win(1'b1, 4'h3, 1'b0, 1'b0, 1'b0, "chg_3");
    for (int w = 0; w < 4; w++) win(1'b1, 4'h7, 1'b0, w == 3, 1'b0, "chg_7");
    win(1'b1, 4'hA, 1'b0, 1'b0, 1'b0, "chg_held_a");
    for (int w = 0; w < 4; w++) win(1'b0, 4'h0, 1'b0, 1'b0, w == 3, "chg_rel");
    chk("chg_head", {11'd0, key_valid, key_code}, 16'h17);
    pop();
    chk("chg_single", 16'(key_valid), 16'h0);

    // 5. FIFO limits
    for (int k = 1; k <= 4; k++) press_seq(4'(k), 1'b0, "fill");
    chk("full_after4", {13'd0, key_valid, full, overflow}, 16'h6);
    press_seq(4'h5, 1'b0, "drop5");
    chk("ovf_after5", {11'd0, full, overflow, key_code}, 16'h31);
    for (int k = 1; k <= 4; k++) begin
      chk("drain", 16'(key_code), 16'(k));
      pop();
    end
    chk("drained", {11'd0, key_valid, key_code}, 16'h00);
    pop();
    chk("pop_empty", {11'd0, key_valid, key_code}, 16'h00);
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    chk("ovf_cleared", 16'(overflow), 16'h0);
    for (int k = 1; k <= 4; k++) press_seq(4'(k), 1'b0, "refill");
    press_seq(4'h6, 1'b1, "pushpop");
    chk("pushpop_state", {10'd0, full, overflow, key_code}, 16'h22);
    chk("drain2_0", 16'(key_code), 16'h2); pop();
    chk("drain2_1", 16'(key_code), 16'h3); pop();
    chk("drain2_2", 16'(key_code), 16'h4); pop();
    chk("drain2_3", 16'(key_code), 16'h6); pop();
    chk("drain2_empty", 16'(key_valid), 16'h0);

    // 6. Reset while 0x9 is held with one entry queued
    for (int w = 0; w < 5; w++) win(1'b1, 4'h9, 1'b0, w == 3, 1'b0, "pre_rst");
    chk("pre_rst_head", {11'd0, key_valid, key_code}, 16'h19);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_outs", outs(), 16'h0);
    tick(); tick();
    rst_n = 1'b1; phase = 0;
    for (int w = 0; w < 4; w++) win(1'b1, 4'h9, 1'b0, w == 3, 1'b0, "post_rst");
    chk("post_rst_head", {11'd0, key_valid, key_code}, 16'h19);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_event_fifo.md
Name: key_event_fifo

Overview:
- Sits directly downstream of the 4x4 keypad scanner and consumes its key code and "no valid row" flag.
- Debounces scanner hits over whole scan windows and turns a held key into exactly one press event.
- Queues pressed key codes in a small first-word-fall-through FIFO, which the control logic pops one at a time.

Parameters:
STABLE_SCANS, 4, consecutive scan windows with the same code needed to accept a press (legal range 2..15)
RELEASE_SCANS, 4, consecutive hit-free windows needed to accept a release (legal range 2..15)
DEPTH, 4, FIFO entries, power of two, 2..16

Ports:
clk  input  1  system clock; same clock as the scanner
rst_n  input  1  asynchronous active-low reset
posicion  input  4  key code from the scanner (row*4+col)
opr  input  1  scanner flag; 0 = a one-hot row was seen this cycle, 1 = no valid hit
rd_en  input  1  pop the head entry; ignored when empty
clr_ovf  input  1  clears the overflow flag
key_code  output  4  FIFO head; 0 when empty
key_valid  output  1  FIFO not empty
full  output  1  FIFO holds DEPTH entries
overflow  output  1  sticky; a press was dropped because the FIFO was full
press_pulse  output  1  one-cycle strobe when a press is accepted
release_pulse  output  1  one-cycle strobe when a release is accepted

Behaviour:
- Reset (async, rst_n=0): all outputs 0, FIFO empty, state IDLE, all counters 0. Release is synchronous to clk.
- Scan window: an internal free-running 2-bit win_cnt defines 4-cycle windows. The window ends on the cycle where win_cnt==3. No phase alignment with the scanner is required.
- Window sampling: every cycle with opr==0 sets hit_acc and captures posicion into code_acc; the end-of-window cycle is included.
  - At window end: hit_w = hit_acc | ~opr; code_w = ~opr ? posicion : code_acc.
  - hit_acc then clears. If several hits occur in one window, the last one wins.
- FSM, evaluated only at window end:
  - IDLE: hit_w -> DEBOUNCE with cand=code_w, cnt=1.
  - DEBOUNCE:
    - hit_w and code_w==cand -> cnt+1. When that reaches STABLE_SCANS -> HELD, push cand, press_pulse.
    - hit_w and a different code -> cand=code_w, cnt=1.
    - no hit -> IDLE.
  - HELD: hit_w with any code -> stay; other keys are ignored until release. No hit -> RELEASE with cnt=1.
  - RELEASE:
    - no hit -> cnt+1. Reaching RELEASE_SCANS -> IDLE, release_pulse.
    - hit_w -> HELD, counter cleared. No new press is generated.
- Latency: press_pulse, key_valid and the new count are all registered at the window-end edge. They are visible in the following cycle. Pulses are high for exactly 1 cycle.
- FIFO:
  - First-word-fall-through: key_code shows the head whenever key_valid=1.
  - Pop takes effect on the rd_en edge; the next entry appears the following cycle.
  - Push and pop in the same cycle: both occur and count is unchanged. This also holds when full, so no overflow is raised.
  - Push when full without pop: entry dropped, overflow<=1.
  - Pop when empty: no effect.
  - Pointers wrap modulo DEPTH; the count uses log2(DEPTH)+1 bits.
- Overflow: stays 1 until clr_ovf. If clr_ovf and a new drop coincide, overflow stays 1.
- Reset mid-operation: all state is lost. A key still held after reset must be debounced again from IDLE and produces a new press.

Decomposition:
- Shared definitions include file keypad_defs:
  - FSM state encodings IDLE/DEBOUNCE/HELD/RELEASE (2 bits).
  - Key-code width 4.
  - Scan window length 4.
- One sub-module, key_fifo. It is a parameterised FWFT FIFO with push, pop, full, empty and count, and is instantiated once. The FSM and window logic stay in key_event_fifo.

Test Plan:
1. Reset: hold rst_n=0 with opr toggling -> all outputs 0; after release, key_valid=0 and no pulses while opr=1 constant.
2. Clean press: opr=0 one cycle per 4 with posicion=0x5 for 6 windows, then opr=1 for 5 windows.
   - press_pulse exactly once, at the end of window 4; key_code=0x5, key_valid=1.
   - release_pulse once, 4 windows after the last hit.
3. Bounce: 0x5 for 2 windows, 1 window gap, 0x5 for 4 windows -> single press_pulse after the 4th window of the second burst.
4. Code change: 0x3 for 2 windows, then 0x7 for 4 windows -> only 0x7 pushed.
   - A 0xA hit during HELD is ignored; no second push.
5. FIFO limits: presses 0x1..0x5 separated by releases, rd_en=0.
   - full=1 after 0x4; 0x5 dropped; overflow=1.
   - Pops return 0x1, 0x2, 0x3, 0x4, then key_valid=0.
   - clr_ovf -> overflow=0.
   - Push and pop in the same cycle while full -> overflow stays 0.
6. Reset mid-HELD: with 0x9 in HELD and 1 entry queued, pulse rst_n low.
   - FIFO empty, no pulses.
   - Key still held -> press_pulse again after 4 windows, key_code=0x9.
